ons_inv: RTL

- Sequential inverse of the fixed-ratio scaler. The forward scaler is Y = round-half-up(X*28.5), which equals ceil(57*X/2), with X 6-bit and Y 12-bit.
- This block takes a 12-bit Y and recovers X by multi-cycle restoring division of 2*Y by 57.
- It reports whether Y is exactly reachable from some 6-bit X.
- It sits on the readback path after the scaler, with a start/done handshake towards the controlling logic.

---
 rtl/ons_inv.sv | 102 ++++++++++
 1 files changed

// File: rtl/ons_inv.sv
// Inverse of the x28.5 scaler: recovers X from Y by restoring division of 2*Y by 57,
// one quotient bit per clock, and flags whether Y is exactly reachable.
//
// state  | meaning
// IDLE   | waiting for start; last results held on outputs
// DIV    | one restoring-division step per edge, MSB first (13 edges)
// DONE   | single-cycle done pulse, then back to IDLE
module ons_inv #(
    parameter int YW      = 12,
    parameter int XW      = 6,
    parameter int DIVISOR = 57,
    parameter int QW      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [YW-1:0] Y,
    output logic          busy,
    output logic          done,
    output logic [XW-1:0] X,
    output logic [5:0]    rem,
    output logic          match,
    output logic          ovf
);

    localparam int DW = YW + 1;
    localparam int PW = 7;
    localparam int CW = $clog2(DW);
    localparam logic [PW-1:0] DIV_C = PW'(DIVISOR);
    localparam logic [QW-1:0] X_MAX = QW'((1 << XW) - 1);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t          r_state;
    logic [DW-1:0]   r_d;
    logic [PW-1:0]   r_p;
    logic [QW-1:0]   r_q;
    logic [CW-1:0]   r_cnt;

    logic [PW-1:0]   w_pp;
    logic            w_ge;
    logic [PW-1:0]   w_pn;
    logic [QW-1:0]   w_qn;
    logic            w_ovf;

    // P' never exceeds 2*56+1, so 7 bits hold it without overflow
    assign w_pp  = {r_p[PW-2:0], r_d[DW-1]};
    assign w_ge  = (w_pp >= DIV_C);
    assign w_pn  = w_ge ? (w_pp - DIV_C) : w_pp;
    assign w_qn  = {r_q[QW-2:0], w_ge};
    assign w_ovf = (w_qn > X_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_d     <= '0;
            r_p     <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            X       <= '0;
            rem     <= '0;
            match   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_d     <= {Y, 1'b0};
                        r_p     <= '0;
                        r_q     <= '0;
                        r_cnt   <= CW'(DW - 1);
                        busy    <= 1'b1;
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_d   <= {r_d[DW-2:0], 1'b0};
                    r_p   <= w_pn;
                    r_q   <= w_qn;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        X       <= w_ovf ? X_MAX[XW-1:0] : w_qn[XW-1:0];
                        rem     <= w_pn[5:0];
                        ovf     <= w_ovf;
                        match   <= !w_ovf && (w_pn <= PW'(1));
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
